// File: rtl/cop0_pkg.sv
// Shared COP0 register addresses, field positions and sequencer state encodings.
package cop0_pkg;

  localparam logic [4:0] RD_BADVADDR = 5'd8;
  localparam logic [4:0] RD_COUNT    = 5'd9;
  localparam logic [4:0] RD_COMPARE  = 5'd11;
  localparam logic [4:0] RD_STATUS   = 5'd12;
  localparam logic [4:0] RD_CAUSE    = 5'd13;
  localparam logic [4:0] RD_EPC      = 5'd14;
  localparam logic [4:0] RD_EBASE    = 5'd15;
  localparam logic [4:0] RD_ERROREPC = 5'd30;

  localparam logic [2:0] SEL_BADVADDR = 3'd0;
  localparam logic [2:0] SEL_COUNT    = 3'd0;
  localparam logic [2:0] SEL_COMPARE  = 3'd0;
  localparam logic [2:0] SEL_STATUS   = 3'd0;
  localparam logic [2:0] SEL_CAUSE    = 3'd0;
  localparam logic [2:0] SEL_EPC      = 3'd0;
  localparam logic [2:0] SEL_EBASE    = 3'd1;
  localparam logic [2:0] SEL_ERROREPC = 3'd0;

  localparam int STATUS_EXL    = 1;
  localparam int STATUS_ERL    = 2;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_EXC_LSB = 2;
  localparam logic [31:0] CAUSE_EXC_MASK = 32'h0000_007C;

  typedef logic [2:0] cop0_state_t;

  localparam cop0_state_t ST_IDLE        = 3'd0;
  localparam cop0_state_t ST_EXC_EPC     = 3'd1;
  localparam cop0_state_t ST_EXC_BADV    = 3'd2;
  localparam cop0_state_t ST_EXC_CAUSE   = 3'd3;
  localparam cop0_state_t ST_EXC_STATUS  = 3'd4;
  localparam cop0_state_t ST_EXC_VEC     = 3'd5;
  localparam cop0_state_t ST_ERET_STATUS = 3'd6;
  localparam cop0_state_t ST_ERET_PC     = 3'd7;

  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare shadow registers with prescaler, deferred-writeback flag and timer interrupt.
module cop0_timer
  import cop0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_count,
  input  logic        load_compare,
  input  logic [31:0] load_data,
  input  logic        wb_taken,
  output logic [31:0] count_q,
  output logic        count_pend,
  output logic        timer_irq
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [31:0]   compare_q;
  logic          tick;

  // A Count load restarts the prescaler, so it also suppresses this cycle's tick.
  assign tick = (prescaler == PRE_LAST) && !load_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      count_pend <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      if (load_count) begin
        count_q   <= load_data;
        prescaler <= '0;
      end else if (tick) begin
        count_q   <= count_q + 32'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      // A tick landing on the writeback cycle must leave the flag set for the new value.
      if (load_count)    count_pend <= 1'b0;
      else if (tick)     count_pend <= 1'b1;
      else if (wb_taken) count_pend <= 1'b0;

      if (load_compare) compare_q <= load_data;

      if (load_compare)                              timer_irq <= 1'b0;
      else if (tick && (count_q + 32'd1 == compare_q)) timer_irq <= 1'b1;
    end
  end

endmodule

// File: rtl/cop0_sequencer.sv
// Sequences every COP0 register file access: exception entry, ERET, MTC0/MFC0 and Count writeback.
//
// state          | meaning
// IDLE           | pipeline MFC0 on read port; accepts exc/eret/mtc0; Count writeback
// EXC_EPC        | read Status, latch EXL, write EPC when EXL was clear
// EXC_BADV       | write BadVAddr when the exception carries one
// EXC_CAUSE      | read-modify-write Cause ExcCode (and BD when EXL was clear)
// EXC_STATUS     | set Status.EXL
// EXC_VEC        | read EBase, redirect to the general exception vector
// ERET_STATUS    | clear ERL if set, else clear EXL; remember which
// ERET_PC        | read ErrorEPC or EPC and redirect there
module cop0_sequencer
  import cop0_pkg::*;
#(
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] VEC_OFFSET = 32'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_has_badvaddr,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_rd,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_ready,
  input  logic [4:0]  mfc0_rd,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_data,
  output logic        cp0_we,
  output logic [4:0]  cp0_wrd,
  output logic [2:0]  cp0_wsel,
  output logic [31:0] cp0_wdata,
  output logic [4:0]  cp0_rrd,
  output logic [2:0]  cp0_rsel,
  input  logic [31:0] cp0_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        timer_irq
);

  cop0_state_t state_q, state_d;

  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic        has_badv_q;
  logic [31:0] badv_q;
  logic        exl_q;
  logic        erl_q;

  logic        we_raw;
  logic        redirect_raw;
  logic        exc_accept;
  logic        mtc0_accept;
  logic        count_wb;
  logic [31:0] count_q;
  logic        count_pend;
  logic [31:0] cause_new;

  always_comb begin
    cause_new = (cp0_rdata & ~CAUSE_EXC_MASK) | ({27'b0, code_q} << CAUSE_EXC_LSB);
    if (!exl_q) cause_new[CAUSE_BD] = bd_q;
  end

  always_comb begin
    state_d      = state_q;
    we_raw       = 1'b0;
    cp0_wrd      = '0;
    cp0_wsel     = '0;
    cp0_wdata    = '0;
    cp0_rrd      = mfc0_rd;
    cp0_rsel     = mfc0_sel;
    redirect_raw = 1'b0;
    redirect_pc  = '0;
    mtc0_ready   = 1'b0;
    exc_accept   = 1'b0;
    mtc0_accept  = 1'b0;
    count_wb     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mtc0_ready = !exc_valid && !eret_valid;
        if (exc_valid) begin
          exc_accept = 1'b1;
          state_d    = ST_EXC_EPC;
        end else if (eret_valid) begin
          state_d = ST_ERET_STATUS;
        end else if (mtc0_valid) begin
          mtc0_accept = 1'b1;
          we_raw      = 1'b1;
          cp0_wrd     = mtc0_rd;
          cp0_wsel    = mtc0_sel;
          cp0_wdata   = mtc0_data;
        end else if (count_pend) begin
          count_wb  = 1'b1;
          we_raw    = 1'b1;
          cp0_wrd   = RD_COUNT;
          cp0_wsel  = SEL_COUNT;
          cp0_wdata = count_q;
        end
      end
      ST_EXC_EPC: begin
        cp0_rrd  = RD_STATUS;
        cp0_rsel = SEL_STATUS;
        if (!cp0_rdata[STATUS_EXL]) begin
          we_raw    = 1'b1;
          cp0_wrd   = RD_EPC;
          cp0_wsel  = SEL_EPC;
          cp0_wdata = epc_value(pc_q, bd_q);
        end
        state_d = ST_EXC_BADV;
      end
      ST_EXC_BADV: begin
        if (has_badv_q) begin
          we_raw    = 1'b1;
          cp0_wrd   = RD_BADVADDR;
          cp0_wsel  = SEL_BADVADDR;
          cp0_wdata = badv_q;
        end
        state_d = ST_EXC_CAUSE;
      end
      ST_EXC_CAUSE: begin
        cp0_rrd   = RD_CAUSE;
        cp0_rsel  = SEL_CAUSE;
        we_raw    = 1'b1;
        cp0_wrd   = RD_CAUSE;
        cp0_wsel  = SEL_CAUSE;
        cp0_wdata = cause_new;
        state_d   = ST_EXC_STATUS;
      end
      ST_EXC_STATUS: begin
        cp0_rrd   = RD_STATUS;
        cp0_rsel  = SEL_STATUS;
        we_raw    = 1'b1;
        cp0_wrd   = RD_STATUS;
        cp0_wsel  = SEL_STATUS;
        cp0_wdata = cp0_rdata | 32'h0000_0002;
        state_d   = ST_EXC_VEC;
      end
      ST_EXC_VEC: begin
        cp0_rrd      = RD_EBASE;
        cp0_rsel     = SEL_EBASE;
        redirect_raw = 1'b1;
        redirect_pc  = {cp0_rdata[31:12], 12'h000} + VEC_OFFSET;
        state_d      = ST_IDLE;
      end
      ST_ERET_STATUS: begin
        cp0_rrd   = RD_STATUS;
        cp0_rsel  = SEL_STATUS;
        we_raw    = 1'b1;
        cp0_wrd   = RD_STATUS;
        cp0_wsel  = SEL_STATUS;
        cp0_wdata = cp0_rdata[STATUS_ERL] ? (cp0_rdata & ~32'h0000_0004)
                                          : (cp0_rdata & ~32'h0000_0002);
        state_d   = ST_ERET_PC;
      end
      ST_ERET_PC: begin
        cp0_rrd      = erl_q ? RD_ERROREPC  : RD_EPC;
        cp0_rsel     = erl_q ? SEL_ERROREPC : SEL_EPC;
        redirect_raw = 1'b1;
        redirect_pc  = cp0_rdata;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must abort a sequence immediately, including the write of the current cycle.
  assign cp0_we         = we_raw && !reset;
  assign redirect_valid = redirect_raw && !reset;
  assign busy           = (state_q != ST_IDLE);
  assign mfc0_data      = busy ? 32'h0 : cp0_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      has_badv_q <= 1'b0;
      badv_q     <= '0;
      exl_q      <= 1'b0;
      erl_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (exc_accept) begin
        code_q     <= exc_code;
        pc_q       <= exc_pc;
        bd_q       <= exc_bd;
        has_badv_q <= exc_has_badvaddr;
        badv_q     <= exc_badvaddr;
      end
      if (state_q == ST_EXC_EPC)     exl_q <= cp0_rdata[STATUS_EXL];
      if (state_q == ST_ERET_STATUS) erl_q <= cp0_rdata[STATUS_ERL];
    end
  end

  cop0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_count   (mtc0_accept && (mtc0_rd == RD_COUNT)   && (mtc0_sel == SEL_COUNT)),
    .load_compare (mtc0_accept && (mtc0_rd == RD_COMPARE) && (mtc0_sel == SEL_COMPARE)),
    .load_data    (mtc0_data),
    .wb_taken     (count_wb),
    .count_q      (count_q),
    .count_pend   (count_pend),
    .timer_irq    (timer_irq)
  );

endmodule
